// File: rtl/mmio_router_if.sv
// Bus bundle between the LSU data port, mmio_router and its peripheral channels.
// slave is the router's view; master is the LSU/peripheral side that drives it.
interface mmio_router_if #(
   parameter int unsigned N_CH   = 4,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64
);
   logic                     req_valid;
   logic                     req_ready;
   logic                     req_we;
   logic [ADDR_W-1:0]        req_addr;
   logic [DATA_W-1:0]        req_wdata;
   logic [DATA_W/8-1:0]      req_wstrb;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [DATA_W-1:0]        rsp_rdata;
   logic                     rsp_err;
   logic [N_CH-1:0]          ch_req_valid;
   logic [N_CH-1:0]          ch_req_ready;
   logic                     ch_we;
   logic [ADDR_W-1:0]        ch_addr;
   logic [DATA_W-1:0]        ch_wdata;
   logic [DATA_W/8-1:0]      ch_wstrb;
   logic [N_CH-1:0]          ch_rsp_valid;
   logic [N_CH*DATA_W-1:0]   ch_rsp_rdata;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
             ch_req_ready, ch_rsp_valid, ch_rsp_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             ch_req_valid, ch_we, ch_addr, ch_wdata, ch_wstrb
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
             ch_req_ready, ch_rsp_valid, ch_rsp_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             ch_req_valid, ch_we, ch_addr, ch_wdata, ch_wstrb
   );
endinterface

// File: rtl/mmio_router.sv
// Synchronous MMIO router: decodes one LSU request at a time onto N_CH handshaked channels.
// Optional abort timer enabled by defining MMIO_TIMEOUT_EN.
module mmio_router #(
   parameter int unsigned            N_CH        = 4,
   parameter int unsigned            ADDR_W      = 32,
   parameter int unsigned            DATA_W      = 64,
   parameter logic [N_CH*ADDR_W-1:0] CH_BASE     = '0,
   parameter logic [N_CH*8-1:0]      CH_SZLOG2   = {N_CH{8'd12}},
   parameter int unsigned            TIMEOUT_CYC = 255
) (
   input logic          clk,
   input logic          rst,
   mmio_router_if.slave bus
);
   localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic [1:0] {StIdle, StSend, StWait, StResp} state_e;

   state_e            state;
   logic [IDX_W-1:0]  sel;
   logic              hit;
   logic [IDX_W-1:0]  hit_idx;
   logic              sel_rdy;
   logic              sel_rsp;
   logic [DATA_W-1:0] sel_rdata;
   logic              timeout;

   // Descending scan so the lowest matching channel wins.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = int'(N_CH) - 1; i >= 0; i--) begin
         if (((bus.req_addr - CH_BASE[i*ADDR_W +: ADDR_W]) >> CH_SZLOG2[i*8 +: 8]) == '0) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   assign sel_rdy   = bus.ch_req_ready[sel];
   assign sel_rsp   = bus.ch_rsp_valid[sel];
   assign sel_rdata = bus.ch_rsp_rdata[sel*DATA_W +: DATA_W];

`ifdef MMIO_TIMEOUT_EN
   logic [15:0] timer;

   // Fires on the TIMEOUT_CYC-th cycle spent in SEND/WAIT.
   assign timeout = (timer + 16'd1) == 16'(TIMEOUT_CYC);

   always_ff @(posedge clk) begin
      if (rst || state == StIdle) begin
         timer <= '0;
      end else if (state == StSend || state == StWait) begin
         timer <= timer + 16'd1;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^32'(TIMEOUT_CYC);
   assign timeout    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= StIdle;
         sel              <= '0;
         bus.req_ready    <= 1'b1;
         bus.rsp_valid    <= 1'b0;
         bus.rsp_err      <= 1'b0;
         bus.rsp_rdata    <= '0;
         bus.ch_req_valid <= '0;
         bus.ch_we        <= 1'b0;
         bus.ch_addr      <= '0;
         bus.ch_wdata     <= '0;
         bus.ch_wstrb     <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (bus.req_valid) begin
                  bus.req_ready <= 1'b0;
                  bus.ch_we     <= bus.req_we;
                  bus.ch_addr   <= bus.req_addr;
                  bus.ch_wdata  <= bus.req_wdata;
                  bus.ch_wstrb  <= bus.req_wstrb;
                  if (hit) begin
                     sel              <= hit_idx;
                     bus.ch_req_valid <= N_CH'(1) << hit_idx;
                     state            <= StSend;
                  end else begin
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b1;
                     bus.rsp_rdata <= '0;
                     state         <= StResp;
                  end
               end
            end
            StSend: begin
               if (sel_rdy && sel_rsp) begin
                  bus.ch_req_valid <= '0;
                  bus.rsp_valid    <= 1'b1;
                  bus.rsp_err      <= 1'b0;
                  bus.rsp_rdata    <= bus.ch_we ? '0 : sel_rdata;
                  state            <= StResp;
               end else if (timeout) begin
                  bus.ch_req_valid <= '0;
                  bus.rsp_valid    <= 1'b1;
                  bus.rsp_err      <= 1'b1;
                  bus.rsp_rdata    <= '0;
                  state            <= StResp;
               end else if (sel_rdy) begin
                  bus.ch_req_valid <= '0;
                  state            <= StWait;
               end
            end
            StWait: begin
               // A response landing on the timeout cycle still completes normally.
               if (sel_rsp) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b0;
                  bus.rsp_rdata <= bus.ch_we ? '0 : sel_rdata;
                  state         <= StResp;
               end else if (timeout) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_rdata <= '0;
                  state         <= StResp;
               end
            end
            StResp: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.rsp_err   <= 1'b0;
                  bus.rsp_rdata <= '0;
                  bus.req_ready <= 1'b1;
                  state         <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end
endmodule
